series_evaluator: RTL and testbench
===================================

Name: series_evaluator

Overview:
Parametrised, self-sequenced fixed-point power-series engine: computes result = Σ c_k·(s·x²)^k for k = 0..n-1, with s = -1 in alternating mode and +1 otherwise. It stops early when a term's magnitude falls below a threshold.
It is the successor of the existing controller-plus-datapath series pair. It adds an internal FSM, a writable coefficient table, configurable widths and term count, a sign mode, saturation and a start/busy/done handshake.
It sits beside the top-level controller as a single callable unit.

Parameters:
DATA_W, 16, signed two's-complement data width for x, the power term, the term and the accumulator.
FRAC_W, 8, fraction bits of data values (1.0 = 2^FRAC_W).
COEFF_W, 8, unsigned coefficient width.
COEFF_FRAC, 7, fraction bits of coefficients (1.0 = 2^COEFF_FRAC).
MAX_TERMS, 8, coefficient table depth and maximum term count.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  request; sampled only in IDLE.
x  in  DATA_W  signed operand, latched on accepted start.
thr  in  DATA_W  unsigned magnitude threshold, latched on start.
n_terms  in  $clog2(MAX_TERMS+1)  terms requested, latched on start; values above MAX_TERMS are clamped to MAX_TERMS.
alt_sign  in  1  1 = use -x², latched on start.
coeff_we  in  1  coefficient write strobe.
coeff_addr  in  $clog2(MAX_TERMS)  table index.
coeff_wdata  in  COEFF_W  coefficient value.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse; result is valid in that cycle.
result  out  DATA_W  accumulator; held from done until the next accepted start.
terms_used  out  $clog2(MAX_TERMS+1)  number of terms added to the accumulator.
overflow  out  1  sticky per operation: set if any saturation occurred.

Behaviour:
- Reset: state=IDLE; busy, done, result, terms_used, overflow = 0; all coefficient entries = 0. Reset mid-operation aborts the run; no done pulse is produced.
- FSM states: IDLE, SQ, MULC, CHK, POW, DONE.
- IDLE, start=1:
  - latch inputs; p ← 1.0; k ← 0; acc ← 0; overflow ← 0; terms_used ← 0.
  - go to SQ, or straight to DONE if the clamped n_terms = 0.
- SQ: xsq ← sat((x·x) >>> FRAC_W), negated if alt_sign. Go to MULC.
- MULC: t ← sat((p·c[k]) >>> COEFF_FRAC). Go to CHK.
- CHK:
  - if |t| < thr (strict): go to DONE; t is not added.
  - else: acc ← sat(acc + t); terms_used ← terms_used + 1. Then go to DONE if k = n-1; otherwise k ← k+1 and go to POW.
- POW: p ← sat((p·xsq) >>> FRAC_W). Go to MULC.
- DONE: done=1 for this single cycle, then go to IDLE.
- Arithmetic:
  - full-precision products; arithmetic right shift (floor);
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and sets overflow;
  - |t| of the most-negative value is treated as 2^(DATA_W-1).
- Latency, measured from the edge that samples start:
  - all n terms used: done is high in cycle 3n+1;
  - n = 0: done is high in cycle 1;
  - early stop at term k: done is high in cycle 3k+4.
- A single multiplier may be shared across SQ/MULC/POW; the schedule above is normative.
- start while busy: ignored.
- Coefficient write while busy: dropped; table contents are unchanged.
- Coefficient write in IDLE: takes effect on the next edge. A write in the same cycle as an accepted start is applied, and that run uses the new value.
- start in the DONE cycle: ignored. start in the cycle after DONE is accepted.
- result and terms_used are readable during a run but are only defined as valid when done=1.

Test Plan:
1. c = {128, 64, 16}; x=256 (1.0), alt_sign=1, n_terms=3, thr=0 -> done in cycle 10; result=160; terms_used=3; overflow=0.
2. Same as 1 with thr=100 -> term 2 (|32|<100) is rejected; result=128; terms_used=2; done in cycle 10.
3. c0=128, c1=128; x=4096 (16.0), alt_sign=0, n_terms=2, thr=0 -> xsq saturates to 32767; result=32767; overflow=1.
4. n_terms=0 -> done in cycle 1; result=0; terms_used=0. Then n_terms=15 with MAX_TERMS=8 -> exactly 8 terms evaluated; done in cycle 25.
5. Start test 1, then at cycle 4 pulse start and write c0=0 -> both ignored; result=160. Repeat the run with rst pulsed at cycle 5 -> no done; all outputs 0; coefficients 0.
6. Back-to-back operation: start in the cycle after DONE -> accepted; busy rises on the next edge.

Source files
------------

// File: rtl/series_evaluator_if.sv
// Request/response and coefficient-write bundle for the series evaluator.
// The requester drives start, operands and table writes; the evaluator returns status and result.
interface series_evaluator_if #(
    parameter int DATA_W    = 16,
    parameter int COEFF_W   = 8,
    parameter int MAX_TERMS = 8
);
    localparam int NW = $clog2(MAX_TERMS + 1);
    localparam int AW = $clog2(MAX_TERMS);

    logic                     start;
    logic signed [DATA_W-1:0] x;
    logic [DATA_W-1:0]        thr;
    logic [NW-1:0]            n_terms;
    logic                     alt_sign;
    logic                     coeff_we;
    logic [AW-1:0]            coeff_addr;
    logic [COEFF_W-1:0]       coeff_wdata;
    logic                     busy;
    logic                     done;
    logic signed [DATA_W-1:0] result;
    logic [NW-1:0]            terms_used;
    logic                     overflow;

    modport master (
        output start, x, thr, n_terms, alt_sign, coeff_we, coeff_addr, coeff_wdata,
        input  busy, done, result, terms_used, overflow
    );

    modport slave (
        input  start, x, thr, n_terms, alt_sign, coeff_we, coeff_addr, coeff_wdata,
        output busy, done, result, terms_used, overflow
    );
endinterface

// File: rtl/series_evaluator.sv
// Fixed-point power-series engine: result = sum c_k*(s*x^2)^k with early stop on small terms.
// One shared multiplier serves the SQ, MULC and POW steps; every arithmetic step saturates.
module series_evaluator #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int COEFF_W    = 8,
    parameter int COEFF_FRAC = 7,
    parameter int MAX_TERMS  = 8
) (
    input logic         clk,
    input logic         rst,
    series_evaluator_if.slave bus
);
    localparam int NW = $clog2(MAX_TERMS + 1);
    localparam int AW = $clog2(MAX_TERMS);
    localparam int PW = 2 * DATA_W + 1;

    localparam logic signed [PW-1:0]     MAX_W  = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0]     MIN_W  = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] ONE_P  = {{(DATA_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
    localparam logic [DATA_W-1:0]        ONE_D  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W:0]          ONE_E  = {{DATA_W{1'b0}}, 1'b1};
    localparam logic [NW-1:0]            ONE_N  = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0]            MAX_N  = NW'(MAX_TERMS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ   = 3'd1,
        MULC = 3'd2,
        CHK  = 3'd3,
        POW  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Clamp a wide value into DATA_W; the top bit of the return value flags saturation.
    function automatic logic [DATA_W:0] sat_fn(input logic signed [PW-1:0] v);
        logic [DATA_W:0] r;
        if (v > MAX_W) begin
            r = {1'b1, MAX_W[DATA_W-1:0]};
        end else if (v < MIN_W) begin
            r = {1'b1, MIN_W[DATA_W-1:0]};
        end else begin
            r = {1'b0, v[DATA_W-1:0]};
        end
        return r;
    endfunction

    state_t                   state_r, state_next_s;
    logic signed [DATA_W-1:0] x_r, xsq_r, p_r, t_r, acc_r;
    logic [DATA_W-1:0]        thr_r;
    logic [NW-1:0]            n_r, k_r, terms_r, n_clamp_s;
    logic                     alt_r, ovf_r, done_r, busy_r;
    logic [COEFF_W-1:0]       coeff_mem [MAX_TERMS];

    logic signed [PW-1:0]     mul_a_s, mul_b_s, prod_s, shifted_s, sum_s;
    logic [DATA_W:0]          mul_sat_s, add_sat_s, t_ext_s, t_abs_s;
    logic [DATA_W-1:0]        xsq_next_s;
    logic                     below_s, last_s;

    assign n_clamp_s = (bus.n_terms > MAX_N) ? MAX_N : bus.n_terms;
    assign last_s    = (k_r == n_r - ONE_N);

    // Shared multiplier operand selection, saturation and term-magnitude test.
    always_comb begin
        mul_a_s = {{(PW-DATA_W){x_r[DATA_W-1]}}, x_r};
        mul_b_s = {{(PW-DATA_W){x_r[DATA_W-1]}}, x_r};
        case (state_r)
            MULC: begin
                mul_a_s = {{(PW-DATA_W){p_r[DATA_W-1]}}, p_r};
                mul_b_s = {{(PW-COEFF_W){1'b0}}, coeff_mem[k_r[AW-1:0]]};
            end
            POW: begin
                mul_a_s = {{(PW-DATA_W){p_r[DATA_W-1]}}, p_r};
                mul_b_s = {{(PW-DATA_W){xsq_r[DATA_W-1]}}, xsq_r};
            end
            default: begin
                mul_a_s = {{(PW-DATA_W){x_r[DATA_W-1]}}, x_r};
                mul_b_s = {{(PW-DATA_W){x_r[DATA_W-1]}}, x_r};
            end
        endcase
        prod_s     = mul_a_s * mul_b_s;
        shifted_s  = (state_r == MULC) ? (prod_s >>> COEFF_FRAC) : (prod_s >>> FRAC_W);
        mul_sat_s  = sat_fn(shifted_s);
        xsq_next_s = alt_r ? (~mul_sat_s[DATA_W-1:0] + ONE_D) : mul_sat_s[DATA_W-1:0];
        sum_s      = {{(PW-DATA_W){acc_r[DATA_W-1]}}, acc_r} + {{(PW-DATA_W){t_r[DATA_W-1]}}, t_r};
        add_sat_s  = sat_fn(sum_s);
        // The most-negative term has magnitude 2^(DATA_W-1), so work one bit wider.
        t_ext_s    = {t_r[DATA_W-1], t_r};
        t_abs_s    = t_r[DATA_W-1] ? (~t_ext_s + ONE_E) : t_ext_s;
        below_s    = (t_abs_s < {1'b0, thr_r});
    end

    // Next-state decode for the evaluation sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = (n_clamp_s == {NW{1'b0}}) ? DONE : SQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SQ:   state_next_s = MULC;
            MULC: state_next_s = CHK;
            CHK: begin
                if (below_s || last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = POW;
                end
            end
            POW:     state_next_s = MULC;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register, datapath registers and coefficient table.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            x_r     <= {DATA_W{1'b0}};
            xsq_r   <= {DATA_W{1'b0}};
            p_r     <= {DATA_W{1'b0}};
            t_r     <= {DATA_W{1'b0}};
            acc_r   <= {DATA_W{1'b0}};
            thr_r   <= {DATA_W{1'b0}};
            n_r     <= {NW{1'b0}};
            k_r     <= {NW{1'b0}};
            terms_r <= {NW{1'b0}};
            alt_r   <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            for (int i = 0; i < MAX_TERMS; i++) begin
                coeff_mem[i] <= {COEFF_W{1'b0}};
            end
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == DONE);
            busy_r  <= (state_next_s != IDLE);
            if (bus.coeff_we && (state_r == IDLE)) begin
                coeff_mem[bus.coeff_addr] <= bus.coeff_wdata;
            end
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        x_r     <= bus.x;
                        thr_r   <= bus.thr;
                        n_r     <= n_clamp_s;
                        alt_r   <= bus.alt_sign;
                        p_r     <= ONE_P;
                        k_r     <= {NW{1'b0}};
                        acc_r   <= {DATA_W{1'b0}};
                        terms_r <= {NW{1'b0}};
                        ovf_r   <= 1'b0;
                    end
                end
                SQ: begin
                    xsq_r <= xsq_next_s;
                    ovf_r <= ovf_r | mul_sat_s[DATA_W];
                end
                MULC: begin
                    t_r   <= mul_sat_s[DATA_W-1:0];
                    ovf_r <= ovf_r | mul_sat_s[DATA_W];
                end
                CHK: begin
                    if (!below_s) begin
                        acc_r   <= add_sat_s[DATA_W-1:0];
                        terms_r <= terms_r + ONE_N;
                        ovf_r   <= ovf_r | add_sat_s[DATA_W];
                        if (!last_s) begin
                            k_r <= k_r + ONE_N;
                        end
                    end
                end
                POW: begin
                    p_r   <= mul_sat_s[DATA_W-1:0];
                    ovf_r <= ovf_r | mul_sat_s[DATA_W];
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.result     = acc_r;
    assign bus.terms_used = terms_r;
    assign bus.overflow   = ovf_r;
endmodule

// File: tb/tb_series_evaluator.sv
// Directed bench for series_evaluator: a vector table of whole runs plus hand-written
// sequences for ignored start/writes, mid-run reset and back-to-back starts.
module tb_series_evaluator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    series_evaluator_if #(.DATA_W(16), .COEFF_W(8), .MAX_TERMS(8)) bus ();

    series_evaluator #(
        .DATA_W(16), .FRAC_W(8), .COEFF_W(8), .COEFF_FRAC(7), .MAX_TERMS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]         c1;
        logic signed [15:0] x;
        logic [15:0]        thr;
        logic [3:0]         n;
        logic               alt;
        int                 exp_result;
        int                 exp_terms;
        int                 exp_ovf;
        int                 exp_cyc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_coeff(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk);
        @(negedge clk);
        bus.coeff_we    = 1'b1;
        bus.coeff_addr  = a;
        bus.coeff_wdata = d;
        @(posedge clk);
        #1;
        bus.coeff_we = 1'b0;
    endtask

    // Leaves the bench #1 after the edge that sampled start, i.e. in cycle 1.
    task automatic apply(input logic signed [15:0] xv, input logic [15:0] th,
                         input logic [3:0] n, input logic al);
        @(posedge clk);
        @(negedge clk);
        bus.x        = xv;
        bus.thr      = th;
        bus.n_terms  = n;
        bus.alt_sign = al;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int first_cyc, output int cyc);
        cyc = 0;
        for (int i = first_cyc; i <= 200; i++) begin
            if (bus.done) begin
                cyc = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cyc;
        int seen;

        // c0=128, c1 per vector, c2=16, rest 0; thresholds and signs exercise early stop and saturation.
        vecs[0] = '{8'd64,  16'sd256,  16'd0,   4'd3,  1'b1, 160,    3, 0, 10};
        vecs[1] = '{8'd64,  16'sd256,  16'd100, 4'd3,  1'b1, 128,    2, 0, 10};
        vecs[2] = '{8'd64,  16'sd256,  16'd0,   4'd0,  1'b1, 0,      0, 0, 1};
        vecs[3] = '{8'd64,  16'sd256,  16'd300, 4'd3,  1'b1, 0,      0, 0, 4};
        vecs[4] = '{8'd64,  16'sd256,  16'd256, 4'd3,  1'b1, 256,    1, 0, 7};
        vecs[5] = '{8'd64,  16'sd256,  16'd0,   4'd15, 1'b0, 416,    8, 0, 25};
        vecs[6] = '{8'd128, 16'sd4096, 16'd0,   4'd2,  1'b0, 32767,  2, 1, 7};
        vecs[7] = '{8'd128, 16'sd4096, 16'd0,   4'd2,  1'b1, -32511, 2, 1, 7};
        vecs[8] = '{8'd64,  -16'sd512, 16'd0,   4'd2,  1'b0, 768,    2, 0, 7};

        bus.start = 1'b0; bus.x = 16'sd0; bus.thr = 16'd0; bus.n_terms = 4'd0;
        bus.alt_sign = 1'b0; bus.coeff_we = 1'b0; bus.coeff_addr = 3'd0; bus.coeff_wdata = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_result", int'(bus.result), 0);
        chk("reset_terms", int'(bus.terms_used), 0);
        chk("reset_ovf", int'(bus.overflow), 0);

        write_coeff(3'd0, 8'd128);
        write_coeff(3'd2, 8'd16);

        for (int v = 0; v < 9; v++) begin
            write_coeff(3'd1, vecs[v].c1);
            apply(vecs[v].x, vecs[v].thr, vecs[v].n, vecs[v].alt);
            wait_done(1, cyc);
            chk($sformatf("v%0d_cycle", v), cyc, vecs[v].exp_cyc);
            chk($sformatf("v%0d_result", v), int'(bus.result), vecs[v].exp_result);
            chk($sformatf("v%0d_terms", v), int'(bus.terms_used), vecs[v].exp_terms);
            chk($sformatf("v%0d_ovf", v), int'(bus.overflow), vecs[v].exp_ovf);
        end

        // Start and coefficient write while busy are both dropped.
        write_coeff(3'd1, 8'd64);
        apply(16'sd256, 16'd0, 4'd3, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1; bus.x = 16'sd0; bus.n_terms = 4'd1;
        bus.coeff_we = 1'b1; bus.coeff_addr = 3'd0; bus.coeff_wdata = 8'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.coeff_we = 1'b0;
        wait_done(5, cyc);
        chk("busy_ign_cycle", cyc, 10);
        chk("busy_ign_result", int'(bus.result), 160);
        apply(16'sd256, 16'd0, 4'd3, 1'b1);
        wait_done(1, cyc);
        chk("coeff_kept_result", int'(bus.result), 160);

        // Reset in cycle 5 aborts the run and clears the table.
        apply(16'sd256, 16'd0, 4'd3, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_terms", int'(bus.terms_used), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen++;
            @(posedge clk);
            #1;
        end
        chk("rst_no_done", seen, 0);
        apply(16'sd256, 16'd0, 4'd3, 1'b1);
        wait_done(1, cyc);
        chk("rst_coeff_result", int'(bus.result), 0);
        chk("rst_coeff_terms", int'(bus.terms_used), 3);

        // Back-to-back: start held through DONE is accepted only in the following IDLE cycle.
        write_coeff(3'd0, 8'd128);
        write_coeff(3'd1, 8'd64);
        write_coeff(3'd2, 8'd16);
        apply(16'sd256, 16'd0, 4'd0, 1'b1);
        wait_done(1, cyc);
        chk("b2b_first_cycle", cyc, 1);
        bus.start = 1'b1; bus.n_terms = 4'd3; bus.x = 16'sd256; bus.alt_sign = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_done_ignored", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_busy_rise", int'(bus.busy), 1);
        wait_done(1, cyc);
        chk("b2b_cycle", cyc, 10);
        chk("b2b_result", int'(bus.result), 160);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
